pipelined_adder: RTL and testbench
==================================

Name: pipelined_adder

Overview:
- Parametrised, pipelined add/subtract unit; next generation of the team's combinational 32-bit adder.
- Splits a WIDTH-bit operation into STAGES equal slices. Each stage resolves one slice and registers its carry into the next stage.
- Operands enter and results leave through valid/ready handshakes, so it drops into streaming datapaths between FIFOs or other arithmetic blocks.

Parameters:
- WIDTH, 32, operand and sum width in bits; must be a multiple of STAGES.
- STAGES, 4, number of pipeline stages and slices; 1 ≤ STAGES ≤ WIDTH.
- SLICE_W, WIDTH/STAGES, derived slice width; not overridable.

Ports:
- clk  in  1  rising-edge clock.
- rst_n  in  1  asynchronous active-low reset.
- in_valid  in  1  operand beat valid.
- in_ready  out  1  block accepts a beat this cycle.
- a  in  WIDTH  operand A.
- b  in  WIDTH  operand B.
- cin  in  1  carry-in (add) or borrow-in complement (sub).
- sub  in  1  0 = A+B+cin; 1 = A+~B+cin (A−B when cin=1).
- out_valid  out  1  result beat valid.
- out_ready  in  1  downstream accepts result.
- sum  out  WIDTH  result bits.
- carry_out  out  1  carry from MSB slice.
- overflow  out  1  signed overflow of the full WIDTH result.

Behaviour:
- Reset (async assert, sync release):
  - all stage valids = 0, all data/carry registers = 0.
  - out_valid = 0, sum = 0, carry_out = 0, overflow = 0.
  - in_ready = 1 in the first cycle after release.
- Global advance enable: adv = !out_valid || out_ready. in_ready = adv. Every pipeline register loads only when adv = 1.
- Accept: a beat is taken when in_valid && in_ready. A stage's valid register loads the valid of the stage before it, so bubbles propagate as holes. Bubbles are not squeezed out.
- Stage k (k = 0..STAGES−1):
  - adds slice k of A and of B' (B' = sub ? ~B : B) plus the carry from stage k−1. Stage 0 uses cin.
  - registers the SLICE_W-bit partial sum and 1-bit carry.
- Skew and de-skew: upper operand slices are delayed by k registers; lower result slices are delayed by STAGES−1−k registers. All slices of one beat present together at the output.
- Latency: exactly STAGES cycles from accept to out_valid, with out_ready held at 1. Throughput is 1 beat/cycle.
- Flags:
  - carry_out = carry from the final slice.
  - overflow = (A[W−1] == B'[W−1]) && (sum[W−1] != A[W−1]); the MSBs are carried alongside the pipeline.
  - Width rule: sum is modulo 2^WIDTH; carry_out is bit WIDTH of the exact result.
- Backpressure: while out_valid && !out_ready, the whole pipe holds. Outputs stay stable and in_ready = 0. Input a/b/cin/sub are ignored while in_ready = 0.
- Simultaneous accept and drain: when out_valid && out_ready && in_valid, both happen in the same cycle.
- Reset mid-operation: all in-flight beats are discarded with no partial output. out_valid drops in the same cycle rst_n asserts.
- STAGES = 1: degenerates to a single registered adder with 1-cycle latency.

Optional Feature:
- Macro: PIPELINED_ADDER_SAT_EN.
- Defined:
  - adds input sat_en (1 bit), carried with the beat.
  - when set and overflow = 1, sum clamps to the signed limit: 0x7FFF_FFFF if A[W−1] = 0, else 0x8000_0000 (shown for WIDTH = 32).
  - carry_out and overflow still report the unclamped values.
  - the clamp sits in the final output register; latency is unchanged.
- Undefined: sat_en port is absent; sum always wraps.

Decomposition:
- Package adder_pkg holds:
  - ADD_WIDTH_DEFAULT = 32 and ADD_STAGES_DEFAULT = 4.
  - the op encoding: OP_ADD = 0, OP_SUB = 1.
  - function sat_limit(width, sign).
- Sub-module adder_slice (parameter SLICE_W): registered slice adder with ports en, a_s, b_s, c_in, s_q, c_q. It is instantiated STAGES times in a generate loop.
- Skew/de-skew delay lines are generate-loop registers inside pipelined_adder.

Test Plan (WIDTH = 32, STAGES = 4, out_ready = 1 unless stated):
- Basic add:
  - a = 8589931, b = 10, cin = 0, sub = 0 → after 4 cycles: sum = 8589941, carry_out = 0, overflow = 0.
- Carry ripples through all slices:
  - a = 0xFFFF_FFFF, b = 0x0000_0001 → sum = 0, carry_out = 1, overflow = 0.
- Subtract and signed overflow:
  - a = 25, b = 12, sub = 1, cin = 1 → sum = 13, carry_out = 1.
  - a = 0x7FFF_FFFF, b = 1, add → sum = 0x8000_0000, overflow = 1.
  - with PIPELINED_ADDER_SAT_EN defined and sat_en = 1, the last case gives sum = 0x7FFF_FFFF.
- Streaming and backpressure:
  - 8 back-to-back beats, out_ready low for cycles 6–8 → in_ready = 0 during the stall.
  - outputs are held stable, no beat is lost or duplicated, and results come out in order.
- Reset mid-flight:
  - 3 beats in flight, then rst_n pulsed low for 1 cycle → out_valid = 0 immediately.
  - no stale results afterwards; the next beat appears exactly 4 cycles after accept.
- Parameter sweep:
  - STAGES = 1 and WIDTH = 8, STAGES = 8.
  - 1000 random beats are checked against a reference model (A + B' + cin); latency equals STAGES.

Source files
------------

// File: rtl/pipelined_adder_pkg.sv
// -----------------------------------------------------------------------------
// adder_pkg
// Shared definitions for the pipelined add/subtract unit:
//   ADD_WIDTH_DEFAULT / ADD_STAGES_DEFAULT : default geometry (32 bits, 4 stages)
//   op_e                                   : operation encoding on the sub input
//   sat_limit(width, sign)                 : signed saturation value for a width;
//                                            sign = 0 -> max positive, 1 -> min negative
// Optional feature macro used by the block: PIPELINED_ADDER_SAT_EN
// -----------------------------------------------------------------------------
package adder_pkg;

   localparam int unsigned ADD_WIDTH_DEFAULT  = 32;
   localparam int unsigned ADD_STAGES_DEFAULT = 4;
   localparam int unsigned ADD_MAX_WIDTH      = 64;

   typedef enum logic {
      OP_ADD = 1'b0,
      OP_SUB = 1'b1
   } op_e;

   // Result is ADD_MAX_WIDTH wide; callers truncate to their own width.
   function automatic logic [ADD_MAX_WIDTH-1:0] sat_limit(input int unsigned width,
                                                          input logic        sign);
      logic [ADD_MAX_WIDTH-1:0] one;
      logic [ADD_MAX_WIDTH-1:0] msb;
      one = {{(ADD_MAX_WIDTH-1){1'b0}}, 1'b1};
      msb = one << (width - 1);
      return sign ? msb : (msb - one);
   endfunction

endpackage

// File: rtl/pipelined_adder_if.sv
// -----------------------------------------------------------------------------
// pipelined_adder_if
// Operand/result stream bundle for pipelined_adder.
//   in_valid/in_ready   : operand beat handshake (a, b, cin, sub)
//   out_valid/out_ready : result beat handshake (sum, carry_out, overflow)
//   sat_en              : per-beat saturation request, present only when
//                         PIPELINED_ADDER_SAT_EN is defined
// master = stream source/sink (bench or upstream logic), slave = the adder.
// -----------------------------------------------------------------------------
interface pipelined_adder_if
   import adder_pkg::*;
#(
   parameter int unsigned WIDTH = ADD_WIDTH_DEFAULT
);

   logic             in_valid;
   logic             in_ready;
   logic [WIDTH-1:0] a;
   logic [WIDTH-1:0] b;
   logic             cin;
   logic             sub;
   logic             out_valid;
   logic             out_ready;
   logic [WIDTH-1:0] sum;
   logic             carry_out;
   logic             overflow;
`ifdef PIPELINED_ADDER_SAT_EN
   logic             sat_en;
`endif

   modport master (
`ifdef PIPELINED_ADDER_SAT_EN
      output sat_en,
`endif
      output in_valid, a, b, cin, sub, out_ready,
      input  in_ready, out_valid, sum, carry_out, overflow
   );

   modport slave (
`ifdef PIPELINED_ADDER_SAT_EN
      input  sat_en,
`endif
      input  in_valid, a, b, cin, sub, out_ready,
      output in_ready, out_valid, sum, carry_out, overflow
   );

endinterface

// File: rtl/pipelined_adder_slice.sv
// -----------------------------------------------------------------------------
// adder_slice
// One registered SLICE_W-bit slice of the pipelined adder.
//   clk, rst_n : clock, asynchronous active-low reset
//   en         : load enable (pipeline advance)
//   a_s, b_s   : slice operands (b_s already inverted for subtract)
//   c_in       : carry from the previous slice (or the beat's cin)
//   s_q, c_q   : registered partial sum and carry-out
// -----------------------------------------------------------------------------
module adder_slice
   import adder_pkg::*;
#(
   parameter int unsigned SLICE_W = 8
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic               en,
   input  logic [SLICE_W-1:0] a_s,
   input  logic [SLICE_W-1:0] b_s,
   input  logic               c_in,
   output logic [SLICE_W-1:0] s_q,
   output logic               c_q
);

   logic [SLICE_W-1:0] s_d;
   logic               c_d;

   always_comb begin
      {c_d, s_d} = {1'b0, a_s} + {1'b0, b_s} + {{SLICE_W{1'b0}}, c_in};
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         s_q <= '0;
         c_q <= 1'b0;
      end else if (en) begin
         s_q <= s_d;
         c_q <= c_d;
      end
   end

endmodule

// File: rtl/pipelined_adder.sv
// -----------------------------------------------------------------------------
// pipelined_adder
// WIDTH-bit add/subtract split into STAGES registered slices with valid/ready
// streaming on both sides. Latency STAGES cycles, throughput 1 beat/cycle.
//   clk   : rising-edge clock
//   rst_n : asynchronous active-low reset (clears every stage)
//   bus   : pipelined_adder_if.slave operand/result stream
// Upper operand slices are skewed by k registers before slice k; lower result
// slices are de-skewed by STAGES-1-k registers so a beat leaves in one piece.
// The whole pipe advances on adv = !out_valid || out_ready.
// Optional: PIPELINED_ADDER_SAT_EN adds sat_en and signed saturation of sum.
// -----------------------------------------------------------------------------
module pipelined_adder
   import adder_pkg::*;
#(
   parameter int unsigned WIDTH  = ADD_WIDTH_DEFAULT,
   parameter int unsigned STAGES = ADD_STAGES_DEFAULT
) (
   input  logic             clk,
   input  logic             rst_n,
   pipelined_adder_if.slave bus
);

   localparam int unsigned SLICE_W = WIDTH / STAGES;

   logic               adv;
   logic [WIDTH-1:0]   b_eff;
   logic [SLICE_W-1:0] a_stage    [STAGES];
   logic [SLICE_W-1:0] b_stage    [STAGES];
   logic               c_in_stage [STAGES];
   logic [SLICE_W-1:0] s_stage    [STAGES];
   logic               c_stage    [STAGES];
   logic [SLICE_W-1:0] res_slice  [STAGES];
   logic [STAGES-1:0]  vld_d, vld_q;
   logic               a_msb_d, a_msb_q;
   logic               b_msb_d, b_msb_q;
   logic [WIDTH-1:0]   sum_raw;
   logic               ovf;

   always_comb begin
      adv   = !vld_q[STAGES-1] || bus.out_ready;
      b_eff = (op_e'(bus.sub) == OP_SUB) ? ~bus.b : bus.b;
   end

   // Valid shift register: holes from idle input cycles travel with the beats.
   always_comb begin
      vld_d[0] = bus.in_valid;
      for (int unsigned i = 1; i < STAGES; i++) vld_d[i] = vld_q[i-1];
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)   vld_q <= '0;
      else if (adv) vld_q <= vld_d;
   end

   for (genvar k = 0; k < STAGES; k++) begin : g_stage
      if (k == 0) begin : g_first
         assign a_stage[k]    = bus.a[SLICE_W-1:0];
         assign b_stage[k]    = b_eff[SLICE_W-1:0];
         assign c_in_stage[k] = bus.cin;
      end else begin : g_skew
         logic [2*SLICE_W-1:0] skw_d [k];
         logic [2*SLICE_W-1:0] skw_q [k];

         always_comb begin
            skw_d[0] = {bus.a[k*SLICE_W +: SLICE_W], b_eff[k*SLICE_W +: SLICE_W]};
            for (int unsigned i = 1; i < k; i++) skw_d[i] = skw_q[i-1];
         end

         always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
               for (int unsigned i = 0; i < k; i++) skw_q[i] <= '0;
            end else if (adv) begin
               skw_q <= skw_d;
            end
         end

         assign {a_stage[k], b_stage[k]} = skw_q[k-1];
         assign c_in_stage[k]            = c_stage[k-1];
      end

      adder_slice #(.SLICE_W(SLICE_W)) u_slice (
         .clk   (clk),
         .rst_n (rst_n),
         .en    (adv),
         .a_s   (a_stage[k]),
         .b_s   (b_stage[k]),
         .c_in  (c_in_stage[k]),
         .s_q   (s_stage[k]),
         .c_q   (c_stage[k])
      );

      if (k < STAGES - 1) begin : g_deskew
         localparam int unsigned DEPTH = STAGES - 1 - k;
         logic [SLICE_W-1:0] dsk_d [DEPTH];
         logic [SLICE_W-1:0] dsk_q [DEPTH];

         always_comb begin
            dsk_d[0] = s_stage[k];
            for (int unsigned i = 1; i < DEPTH; i++) dsk_d[i] = dsk_q[i-1];
         end

         always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
               for (int unsigned i = 0; i < DEPTH; i++) dsk_q[i] <= '0;
            end else if (adv) begin
               dsk_q <= dsk_d;
            end
         end

         assign res_slice[k] = dsk_q[DEPTH-1];
      end else begin : g_top
         assign res_slice[k] = s_stage[k];
      end
   end

   always_comb begin
      sum_raw = '0;
      for (int unsigned i = 0; i < STAGES; i++) sum_raw[i*SLICE_W +: SLICE_W] = res_slice[i];
   end

   // Operand MSBs are taken at the top slice's input so they are registered
   // in step with the final slice, ready for the overflow check.
   always_comb begin
      a_msb_d = a_stage[STAGES-1][SLICE_W-1];
      b_msb_d = b_stage[STAGES-1][SLICE_W-1];
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         a_msb_q <= 1'b0;
         b_msb_q <= 1'b0;
      end else if (adv) begin
         a_msb_q <= a_msb_d;
         b_msb_q <= b_msb_d;
      end
   end

   always_comb begin
      ovf = (a_msb_q == b_msb_q) && (sum_raw[WIDTH-1] != a_msb_q);
   end

`ifdef PIPELINED_ADDER_SAT_EN
   logic [STAGES-1:0] sat_d, sat_q;

   always_comb begin
      sat_d[0] = bus.sat_en;
      for (int unsigned i = 1; i < STAGES; i++) sat_d[i] = sat_q[i-1];
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)   sat_q <= '0;
      else if (adv) sat_q <= sat_d;
   end

   // Clamp muxes the registered result; it adds no cycle of latency.
   assign bus.sum = (sat_q[STAGES-1] && ovf) ? WIDTH'(sat_limit(WIDTH, a_msb_q)) : sum_raw;
`else
   assign bus.sum = sum_raw;
`endif

   assign bus.in_ready  = adv;
   assign bus.out_valid = vld_q[STAGES-1];
   assign bus.carry_out = c_stage[STAGES-1];
   assign bus.overflow  = ovf;

endmodule

// File: tb/tb_pipelined_adder.sv
module tb_pipelined_adder;
   import adder_pkg::*;

   typedef struct {
      logic [31:0] sum;
      logic        co;
      logic        ov;
      int          acc;   // cycle the beat was presented; -1 = no latency check
   } exp_t;

   logic clk = 1'b0;
   logic rst_n;
   int   cyc = 0;
   int   n_chk = 0;
   int   n_fail = 0;

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   pipelined_adder_if #(.WIDTH(32)) bus0 ();
   pipelined_adder_if #(.WIDTH(32)) bus1 ();
   pipelined_adder_if #(.WIDTH(8))  bus2 ();

   pipelined_adder #(.WIDTH(32), .STAGES(4)) u0 (.clk(clk), .rst_n(rst_n), .bus(bus0.slave));
   pipelined_adder #(.WIDTH(32), .STAGES(1)) u1 (.clk(clk), .rst_n(rst_n), .bus(bus1.slave));
   pipelined_adder #(.WIDTH(8),  .STAGES(8)) u2 (.clk(clk), .rst_n(rst_n), .bus(bus2.slave));

   exp_t q0[$];
   exp_t q1[$];
   exp_t q2[$];

   function automatic void check(input string name, input logic [63:0] act, input logic [63:0] req);
      n_chk++;
      if (act !== req) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, req, $time);
      end
   endfunction

   // Reference: exact A + B' + cin at width w, independent of slicing.
   function automatic exp_t ref_add(input logic [31:0] a, input logic [31:0] b, input logic cin,
                                    input logic sub, input int unsigned w, input int acc);
      logic [32:0] mask;
      logic [31:0] am, bp;
      logic [32:0] full;
      exp_t        e;
      mask   = (33'd1 << w) - 33'd1;
      am     = a & mask[31:0];
      bp     = (sub ? ~b : b) & mask[31:0];
      full   = {1'b0, am} + {1'b0, bp} + {32'd0, cin};
      e.sum  = full[31:0] & mask[31:0];
      e.co   = full[w];
      e.ov   = (am[w-1] == bp[w-1]) && (e.sum[w-1] != am[w-1]);
      e.acc  = acc;
      return e;
   endfunction

   // ---------------- monitor for the 32/4 instance ----------------
   exp_t        e0;
   logic [31:0] prev_sum0;
   logic        prev_co0;
   logic        prev_stall0 = 1'b0;

   always begin
      @(negedge clk); #2;
      if (!rst_n) begin
         prev_stall0 = 1'b0;
      end else begin
         if (prev_stall0) begin
            check("hold_valid", bus0.out_valid, 1);
            check("hold_sum", bus0.sum, prev_sum0);
            check("hold_carry", bus0.carry_out, prev_co0);
         end
         prev_stall0 = bus0.out_valid && !bus0.out_ready;
         prev_sum0   = bus0.sum;
         prev_co0    = bus0.carry_out;
         if (prev_stall0) check("stall_in_ready", bus0.in_ready, 0);
         if (bus0.out_valid && bus0.out_ready) begin
            if (q0.size() == 0) begin
               n_chk++; n_fail++;
               $display("FAIL spurious_out0: got sum 0x%0h, expected no beat", bus0.sum);
            end else begin
               e0 = q0.pop_front();
               check("sum0", bus0.sum, e0.sum);
               check("carry0", bus0.carry_out, e0.co);
               check("ovf0", bus0.overflow, e0.ov);
               if (e0.acc >= 0) check("lat0", 64'(cyc - e0.acc), 64'd4);
            end
         end
      end
   end

   // ---------------- monitors for the sweep instances ----------------
   exp_t e1, e2;

   always begin
      @(negedge clk); #2;
      if (rst_n && bus1.out_valid && bus1.out_ready) begin
         if (q1.size() == 0) begin
            n_chk++; n_fail++;
            $display("FAIL spurious_out1: got sum 0x%0h, expected no beat", bus1.sum);
         end else begin
            e1 = q1.pop_front();
            check("sum1", bus1.sum, e1.sum);
            check("carry1", bus1.carry_out, e1.co);
            check("ovf1", bus1.overflow, e1.ov);
            check("lat1", 64'(cyc - e1.acc), 64'd1);
         end
      end
   end

   always begin
      @(negedge clk); #2;
      if (rst_n && bus2.out_valid && bus2.out_ready) begin
         if (q2.size() == 0) begin
            n_chk++; n_fail++;
            $display("FAIL spurious_out2: got sum 0x%0h, expected no beat", bus2.sum);
         end else begin
            e2 = q2.pop_front();
            check("sum2", {24'd0, bus2.sum}, e2.sum);
            check("carry2", bus2.carry_out, e2.co);
            check("ovf2", bus2.overflow, e2.ov);
            check("lat2", 64'(cyc - e2.acc), 64'd8);
         end
      end
   end

   // ---------------- stimulus ----------------
   task automatic send0(input logic [31:0] a, input logic [31:0] b, input logic cin, input logic sub,
                        input logic sat, input logic [31:0] es, input logic eco, input logic eov,
                        input bit lat);
      exp_t e;
      int   tries;
      @(negedge clk);
      bus0.in_valid = 1'b1;
      bus0.a = a; bus0.b = b; bus0.cin = cin; bus0.sub = sub;
`ifdef PIPELINED_ADDER_SAT_EN
      bus0.sat_en = sat;
`else
      if (sat) $display("note: sat_en ignored in this build");
`endif
      #1;
      tries = 0;
      while (!bus0.in_ready && tries < 50) begin
         @(negedge clk); #1;
         tries++;
      end
      if (!bus0.in_ready) begin
         n_chk++; n_fail++;
         $display("FAIL accept_timeout: got in_ready 0 for 50 cycles, expected 1");
      end else begin
         e.sum = es; e.co = eco; e.ov = eov; e.acc = lat ? cyc : -1;
         q0.push_back(e);
      end
      @(posedge clk);
   endtask

   task automatic idle0();
      @(negedge clk);
      bus0.in_valid = 1'b0;
`ifdef PIPELINED_ADDER_SAT_EN
      bus0.sat_en = 1'b0;
`endif
   endtask

   task automatic drain();
      for (int i = 0; i < 100 && (q0.size() != 0 || q1.size() != 0 || q2.size() != 0); i++)
         @(negedge clk);
      check("drain_q0", 64'(q0.size()), 64'd0);
      check("drain_q1", 64'(q1.size()), 64'd0);
      check("drain_q2", 64'(q2.size()), 64'd0);
   endtask

   // 8-beat streaming table: a, b, sub (cin = sub), expected sum/carry/overflow
   logic [31:0] st_a  [8] = '{32'h1, 32'h0000_FFFF, 32'h1234_5678, 32'hFFFF_FFFF,
                              32'h8000_0000, 32'd100, 32'h0, 32'h8000_0000};
   logic [31:0] st_b  [8] = '{32'h2, 32'h1, 32'h1111_1111, 32'hFFFF_FFFF,
                              32'h8000_0000, 32'd1, 32'h1, 32'h1};
   logic        st_s  [8] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1};
   logic [31:0] st_e  [8] = '{32'h3, 32'h0001_0000, 32'h2345_6789, 32'hFFFF_FFFE,
                              32'h0, 32'd99, 32'hFFFF_FFFF, 32'h7FFF_FFFF};
   logic        st_co [8] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1};
   logic        st_ov [8] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1};

   logic [31:0] ra1, rb1, ra2, rb2;
   logic        rc1, rs1, rc2, rs2;
   int          cnt1, cnt2;

   initial begin
      rst_n = 1'b0;
      bus0.in_valid = 1'b0; bus0.a = '0; bus0.b = '0; bus0.cin = 1'b0; bus0.sub = 1'b0; bus0.out_ready = 1'b1;
      bus1.in_valid = 1'b0; bus1.a = '0; bus1.b = '0; bus1.cin = 1'b0; bus1.sub = 1'b0; bus1.out_ready = 1'b1;
      bus2.in_valid = 1'b0; bus2.a = '0; bus2.b = '0; bus2.cin = 1'b0; bus2.sub = 1'b0; bus2.out_ready = 1'b1;
`ifdef PIPELINED_ADDER_SAT_EN
      bus0.sat_en = 1'b0; bus1.sat_en = 1'b0; bus2.sat_en = 1'b0;
`endif
      repeat (3) @(negedge clk);
      rst_n = 1'b1;
      #1;
      check("rst_out_valid", bus0.out_valid, 0);
      check("rst_sum", bus0.sum, 0);
      check("rst_carry", bus0.carry_out, 0);
      check("rst_ovf", bus0.overflow, 0);
      check("rst_in_ready", bus0.in_ready, 1);

      // directed vectors, back-to-back, latency checked
      send0(32'd8589931,    32'd10,        1'b0, 1'b0, 1'b0, 32'd8589941,   1'b0, 1'b0, 1);
      send0(32'hFFFF_FFFF,  32'h1,         1'b0, 1'b0, 1'b0, 32'h0,         1'b1, 1'b0, 1);
      send0(32'd25,         32'd12,        1'b1, 1'b1, 1'b0, 32'd13,        1'b1, 1'b0, 1);
      send0(32'h7FFF_FFFF,  32'h1,         1'b0, 1'b0, 1'b0, 32'h8000_0000, 1'b0, 1'b1, 1);
      send0(32'd5,          32'd6,         1'b1, 1'b0, 1'b0, 32'd12,        1'b0, 1'b0, 1);
`ifdef PIPELINED_ADDER_SAT_EN
      send0(32'h7FFF_FFFF,  32'h1,         1'b0, 1'b0, 1'b1, 32'h7FFF_FFFF, 1'b0, 1'b1, 1);
      send0(32'h8000_0000,  32'h8000_0000, 1'b0, 1'b0, 1'b1, 32'h8000_0000, 1'b1, 1'b1, 1);
`endif
      idle0();
      drain();

      // streaming with a 3-cycle output stall
      fork
         begin
            for (int i = 0; i < 8; i++)
               send0(st_a[i], st_b[i], st_s[i], st_s[i], 1'b0, st_e[i], st_co[i], st_ov[i], 0);
         end
         begin
            repeat (5) @(negedge clk);
            bus0.out_ready = 1'b0;
            repeat (3) @(negedge clk);
            bus0.out_ready = 1'b1;
         end
      join
      idle0();
      drain();

      // reset with beats in flight
      send0(32'd1, 32'd1, 1'b0, 1'b0, 1'b0, 32'd2, 1'b0, 1'b0, 1);
      send0(32'd2, 32'd2, 1'b0, 1'b0, 1'b0, 32'd4, 1'b0, 1'b0, 1);
      send0(32'd3, 32'd3, 1'b0, 1'b0, 1'b0, 32'd6, 1'b0, 1'b0, 1);
      idle0();
      @(negedge clk);
      check("pre_reset_valid", bus0.out_valid, 1);
      rst_n = 1'b0;
      #1;
      check("reset_valid_drop", bus0.out_valid, 0);
      q0.delete();
      @(negedge clk);
      rst_n = 1'b1;
      #1;
      check("post_reset_in_ready", bus0.in_ready, 1);
      check("post_reset_valid", bus0.out_valid, 0);
      repeat (6) @(negedge clk);
      send0(32'h0F0F_0F0F, 32'h0101_0101, 1'b0, 1'b0, 1'b0, 32'h1010_1010, 1'b0, 1'b0, 1);
      idle0();
      drain();

      // parameter sweep: random beats into 32/1 and 8/8 instances
      cnt1 = 0; cnt2 = 0;
      for (int i = 0; i < 3000 && (cnt1 < 1000 || cnt2 < 1000); i++) begin
         @(negedge clk);
         ra1 = $urandom(); rb1 = $urandom(); rc1 = 1'($urandom_range(0, 1)); rs1 = 1'($urandom_range(0, 1));
         ra2 = $urandom(); rb2 = $urandom(); rc2 = 1'($urandom_range(0, 1)); rs2 = 1'($urandom_range(0, 1));
         bus1.in_valid = (cnt1 < 1000) && ($urandom_range(0, 3) != 0);
         bus1.a = ra1; bus1.b = rb1; bus1.cin = rc1; bus1.sub = rs1;
         bus2.in_valid = (cnt2 < 1000) && ($urandom_range(0, 3) != 0);
         bus2.a = ra2[7:0]; bus2.b = rb2[7:0]; bus2.cin = rc2; bus2.sub = rs2;
         #1;
         if (bus1.in_valid && bus1.in_ready) begin
            q1.push_back(ref_add(ra1, rb1, rc1, rs1, 32, cyc));
            cnt1++;
         end
         if (bus2.in_valid && bus2.in_ready) begin
            q2.push_back(ref_add(ra2, rb2, rc2, rs2, 8, cyc));
            cnt2++;
         end
      end
      @(negedge clk);
      bus1.in_valid = 1'b0;
      bus2.in_valid = 1'b0;
      check("sweep_beats1", 64'(cnt1), 64'd1000);
      check("sweep_beats2", 64'(cnt2), 64'd1000);
      drain();

      repeat (3) @(negedge clk);
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
